// File: rtl/aes_key_reverse_128.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_reverse_128
//  Description : Iterative AES-128 inverse key schedule. Accepts the round-10
//                key and emits round keys 10 down to 0, one per output beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_key_reverse_128 #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         abort,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_key,
    output logic [3:0]   out_round,
    output logic         out_last
);

    generate
        if (NR != 10) begin : g_nr_check
            $error("aes_key_reverse_128: NR must be 10 for AES-128");
        end
    endgenerate

    localparam logic [3:0] c_NR = 4'(NR);

    // Forward AES S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t        r_state;
    logic [127:0]  r_key;
    logic [3:0]    r_round;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_out_last;

    logic [31:0]   w_a, w_b, w_c, w_d;
    logic [31:0]   w_na, w_nb, w_nc, w_nd;
    logic [31:0]   w_rot;
    logic [31:0]   w_sub;
    logic [7:0]    w_rcon;
    logic [127:0]  w_prev_key;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        // Bit index of the entry's MSB is 8*(255-x)+7 == {~x, 3'b111}.
        sbox = c_SBOX[{~x, 3'b111} -: 8];
    endfunction

    always_comb begin
        w_rcon = 8'h00;
        case (r_round)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // One inverse schedule step: the three trailing words unwind by plain XOR,
    // and the leading word needs the recovered last word of the previous round.
    assign {w_a, w_b, w_c, w_d} = r_key;
    assign w_nd  = w_d ^ w_c;
    assign w_nc  = w_c ^ w_b;
    assign w_nb  = w_b ^ w_a;
    assign w_rot = {w_nd[23:0], w_nd[31:24]};

    generate
        for (genvar g = 0; g < 4; g++) begin : g_subword
            assign w_sub[8*g +: 8] = sbox(w_rot[8*g +: 8]);
        end
    endgenerate

    assign w_na       = w_a ^ w_sub ^ {w_rcon, 24'h000000};
    assign w_prev_key = {w_na, w_nb, w_nc, w_nd};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_key       <= '0;
            r_round     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (abort) begin
            r_state     <= ST_IDLE;
            r_key       <= '0;
            r_round     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    if (in_valid && r_in_ready) begin
                        r_key       <= key_last;
                        r_round     <= c_NR;
                        r_state     <= ST_EMIT;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (r_round == 4'd0) begin
                            r_state     <= ST_IDLE;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_key      <= w_prev_key;
                            r_round    <= r_round - 4'd1;
                            r_out_last <= (r_round == 4'd1);
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_key   = r_key;
    assign out_round = r_round;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_reverse_128.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_reverse_128
//  Description : Self-checking bench for aes_key_reverse_128 against a forward
//                key-expansion model with an arithmetically derived S-box.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_reverse_128;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         abort = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] key_last = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_key;
    logic [3:0]   out_round;
    logic         out_last;

    aes_key_reverse_128 #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_last  (key_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_key   (out_key),
        .out_round (out_round),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] c_FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_FIPS_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_FIPS_R9   = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] c_FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   m_sbox [0:255];
    logic [127:0] m_rk   [0:10];

    logic [127:0] got_key   [0:10];
    logic [3:0]   got_round [0:10];
    logic         got_last  [0:10];
    int           got_n;

    typedef struct {
        logic [127:0] key_in;
        logic [3:0]   round;
        logic [127:0] exp_key;
        logic         exp_last;
    } vec_t;

    vec_t vecs [0:5];

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    function automatic void build_sbox();
        logic [7:0] inv, r, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            r = inv;
            s = inv;
            for (int n = 0; n < 4; n++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            m_sbox[x] = s ^ 8'h63;
        end
    endfunction

    function automatic void model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]}
                    ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        int cyc = 0;
        key_last = k;
        in_valid = 1'b1;
        while (!in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("load_ready", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        chk("first_beat_latency", 128'(out_valid), 128'd1);
    endtask

    task automatic collect(input int stall_pct);
        int           cyc = 0;
        logic         stalled = 1'b0;
        logic [127:0] hk = '0;
        logic [3:0]   hr = '0;
        got_n = 0;
        while (got_n < 11 && cyc < 1000) begin
            if (stalled) begin
                chk("stall_key", out_key, hk);
                chk("stall_valid_round", {123'd0, out_valid, out_round}, {123'd0, 1'b1, hr});
            end
            if (out_valid) chk("in_ready_busy", 128'(in_ready), 128'd0);
            out_ready = ($urandom_range(99) >= stall_pct);
            stalled = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    got_key[got_n]   = out_key;
                    got_round[got_n] = out_round;
                    got_last[got_n]  = out_last;
                    got_n++;
                end else begin
                    stalled = 1'b1;
                    hk = out_key;
                    hr = out_round;
                end
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        chk("beat_count", 128'(got_n), 128'd11);
    endtask

    function automatic void check_beats(input string tag);
        for (int k = 0; k < got_n; k++) begin
            chk($sformatf("%s_key_b%0d", tag, k), got_key[k], m_rk[10-k]);
            chk($sformatf("%s_last_round_b%0d", tag, k),
                {123'd0, got_last[k], got_round[k]},
                {123'd0, (k == 10), 4'(10 - k)});
        end
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_idle_valid"}, 128'(out_valid), 128'd0);
        chk({tag, "_idle_ready"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           cyc;
        logic [127:0] rk;

        build_sbox();
        vecs[0] = '{c_FIPS_R10, 4'd10, c_FIPS_R10,  1'b0};
        vecs[1] = '{c_FIPS_R10, 4'd9,  c_FIPS_R9,   1'b0};
        vecs[2] = '{c_FIPS_R10, 4'd1,  c_FIPS_R1,   1'b0};
        vecs[3] = '{c_FIPS_R10, 4'd0,  c_FIPS_KEY,  1'b1};
        vecs[4] = '{c_ZERO_R10, 4'd10, c_ZERO_R10,  1'b0};
        vecs[5] = '{c_ZERO_R10, 4'd0,  128'd0,      1'b1};

        // Reset state while rst is held low
        #12;
        chk("rst_in_ready",  128'(in_ready),  128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_key",   out_key,         128'd0);
        chk("rst_out_round", 128'(out_round), 128'd0);
        chk("rst_out_last",  128'(out_last),  128'd0);
        #11 rst = 1'b1;
        tick();
        tick();
        chk("post_rst_in_ready", 128'(in_ready), 128'd1);

        // Model sanity against published values
        model_expand(c_FIPS_KEY);
        chk("model_fips_r10", m_rk[10], c_FIPS_R10);
        chk("model_fips_r9",  m_rk[9],  c_FIPS_R9);

        // Table-driven known-answer vectors
        for (int i = 0; i < 6; i++) begin
            load_key(vecs[i].key_in);
            collect(0);
            chk($sformatf("vec%0d_key", i), got_key[10 - int'(vecs[i].round)], vecs[i].exp_key);
            chk($sformatf("vec%0d_last", i), 128'(got_last[10 - int'(vecs[i].round)]), 128'(vecs[i].exp_last));
            check_idle($sformatf("vec%0d", i));
        end

        // Backpressure: same sequence under pseudo-random stalls
        model_expand(c_FIPS_KEY);
        load_key(m_rk[10]);
        collect(45);
        check_beats("stall");
        check_idle("stall");

        // Back-to-back keys with in_valid held high
        key_last = c_FIPS_R10;
        in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 50) begin tick(); cyc++; end
        tick();
        key_last = c_ZERO_R10;
        collect(0);
        check_beats("b2b_first");
        check_idle("b2b_gap");
        tick();
        in_valid = 1'b0;
        chk("b2b_second_accept", 128'(out_valid), 128'd1);
        model_expand(128'd0);
        collect(0);
        check_beats("b2b_second");
        chk("b2b_second_r0", got_key[10], 128'd0);

        // Abort at round 5 while stalled
        model_expand(c_FIPS_KEY);
        load_key(m_rk[10]);
        out_ready = 1'b1;
        cyc = 0;
        while (out_round != 4'd5 && cyc < 20) begin tick(); cyc++; end
        out_ready = 1'b0;
        chk("abort_reach_r5", 128'(out_round), 128'd5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", 128'(out_valid), 128'd0);
        chk("abort_ready", 128'(in_ready),  128'd1);
        chk("abort_last",  128'(out_last),  128'd0);
        chk("abort_round", 128'(out_round), 128'd0);
        chk("abort_key",   out_key,         128'd0);
        load_key(m_rk[10]);
        collect(0);
        check_beats("post_abort");

        // Abort coincident with in_valid in IDLE drops the key
        tick();
        key_last = c_FIPS_R10;
        in_valid = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_idle_valid", 128'(out_valid), 128'd0);
        chk("abort_idle_ready", 128'(in_ready),  128'd1);
        tick();
        chk("abort_idle_dropped", 128'(out_valid), 128'd0);

        // Asynchronous reset mid-stream, off a clock edge
        load_key(m_rk[10]);
        out_ready = 1'b1;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 128'(out_valid), 128'd0);
        chk("arst_key",   out_key,         128'd0);
        chk("arst_round", 128'(out_round), 128'd0);
        chk("arst_ready", 128'(in_ready),  128'd0);
        chk("arst_last",  128'(out_last),  128'd0);
        out_ready = 1'b0;
        #3 rst = 1'b1;
        tick();
        tick();
        check_idle("arst_release");
        load_key(m_rk[10]);
        collect(0);
        check_beats("post_arst");

        // Random cipher keys, forward-expanded by the model
        for (int n = 0; n < 1000; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            model_expand(rk);
            load_key(m_rk[10]);
            collect((n % 3 == 0) ? 30 : 0);
            check_beats($sformatf("rnd%0d", n));
            chk($sformatf("rnd%0d_orig", n), got_key[10], rk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_key_reverse_128.md
Name: aes_key_reverse_128

Overview:
Iterative AES-128 inverse key schedule for the decrypt datapath. It accepts the round-10 key through a valid/ready handshake and regenerates the round keys in descending order, 10 down to 0, at one per accepted output beat. It sits between the key-load path and the inverse cipher rounds, so decryption needs only the last round key instead of a full 11-key forward expansion.

Parameters:
NR, 10, number of rounds; only 10 is legal (elaboration-time error otherwise); sets the round counter start value.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
abort  input  1  synchronous flush; returns block to IDLE
in_valid  input  1  key_last valid
in_ready  output  1  block can accept a new key_last
key_last  input  128  round-10 key {w40,w41,w42,w43}, w40 in [127:96]
out_valid  output  1  out_key/out_round valid
out_ready  input  1  consumer accepts current beat
out_key  output  128  round key for out_round, same word ordering as key_last
out_round  output  4  round index of out_key, 10..0
out_last  output  1  high with out_valid when out_round==0

Behaviour:
- Reset (rst low, async): state IDLE; in_ready=0 while rst low, then 1 in IDLE; out_valid=0, out_key=0, out_round=0, out_last=0.
- FSM states: IDLE, EMIT.
- IDLE: in_ready=1, out_valid=0. When in_valid&in_ready: key_reg<=key_last, round<=NR, go to EMIT. First out_valid comes the cycle after accept (latency 1).
- EMIT: in_ready=0, out_valid=1, out_key=key_reg, out_round=round (both registered, no combinational path from inputs).
  - out_ready=0: hold out_key, out_round, out_valid stable. No change of key_reg.
  - out_ready=1 and round!=0: key_reg<=prev(key_reg), round<=round-1, stay in EMIT. Back-to-back beats give one key per cycle.
  - out_ready=1 and round==0: go to IDLE; out_valid drops next cycle; in_ready rises next cycle (no same-cycle reload).
- prev(): current words {a,b,c,d} = round-i words w[4i..4i+3]. New words {a',b',c',d'}:
  - d' = d^c
  - c' = c^b
  - b' = b^a
  - a' = a ^ SubWord(RotWord(d')) ^ {rcon_i,24'b0}
  - RotWord({x3,x2,x1,x0}) = {x2,x1,x0,x3}; SubWord applies the forward AES S-box bytewise.
  - rcon_i indexed by current round i: 1:01, 2:02, 3:04, 4:08, 5:10, 6:20, 7:40, 8:80, 9:1b, 10:36; round 0 never steps.
- Exactly NR+1=11 output beats per accepted key; out_last only on the round-0 beat.
- abort: highest priority after rst. In any state, the next cycle is IDLE, out_valid=0, out_last=0, and round/key_reg are cleared to 0. Asserted in the same cycle as in_valid in IDLE, the key is dropped and in_ready is still 1.
- in_valid while in EMIT is ignored (in_ready=0); the upstream holds it.
- Async reset mid-stream: outputs return to reset values immediately; no partial beats resume.
- S-box and the one-round step are pure combinational on key_reg; the one-round critical path (3 XOR levels + S-box) must meet the same timing as one forward expansion round.

Test Plan:
- FIPS-197 key: load key_last=d014f9a8_c9ee2589_e13f0cc8_b6630ca6, out_ready=1 -> beat0 round 10 = same value; beat1 round 9 = ac7766f3_19fadc21_28d12941_575c006e; beat9 round 1 = a0fafe17_88542cb1_23a33939_2a6c7605; beat10 round 0 = 2b7e1516_28aed2a6_abf71588_09cf4f3c with out_last=1; then IDLE with in_ready=1 one cycle later.
- Backpressure: same key, out_ready toggled pseudo-randomly -> out_key/out_round stable while stalled; the 11-beat sequence is identical to the no-stall run; no beat dropped or duplicated.
- Back-to-back keys: in_valid held high with two keys (FIPS key, then all-zero cipher's round-10 key b4ef5bcb_3e92e211_23e951cf_6f8f188e) -> second accepted only after the first out_last; second sequence ends at 00000000_00000000_00000000_00000000.
- Abort at round 5 with out_ready=0 -> next cycle out_valid=0, in_ready=1; a fresh load then produces the full correct 11 beats.
- Async reset asserted mid-EMIT, off a clock edge -> outputs zero immediately; after release in_ready=1 and a new load behaves normally.
- Random cross-check: 1000 random cipher keys, forward-expanded by the model to round 10 and loaded -> all 11 beats match the model; round 0 equals the original key.
